// File: rtl/icache_pkg.sv
// Shared types and geometry for the instruction cache.
// Contents: FSM state enum, line/word geometry, index/tag width helpers.
package icache_pkg;

    typedef enum logic {
        LOOKUP = 1'b0,
        REFILL = 1'b1
    } state_e;

    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned LINE_W         = 256;
    localparam int unsigned WORDS_PER_LINE = 8;
    localparam int unsigned OFFSET_W       = $clog2(WORDS_PER_LINE);
    // Byte-offset bits inside a line; the line index starts here.
    localparam int unsigned BLOCK_LSB      = 5;

    // Number of address bits used to select a line.
    function automatic int unsigned index_w(input int unsigned lines);
        return unsigned'($clog2(lines));
    endfunction

    // Address bits above the index that identify which block occupies a line.
    function automatic int unsigned tag_w(input int unsigned lines);
        return ADDR_W - BLOCK_LSB - index_w(lines);
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data storage for a direct-mapped cache.
// Ports: i_clk, i_rst_n (sync, active-low, clears valid bits only),
//        i_clear_valid (invalidate all), combinational read port
//        (i_rd_index -> o_rd_valid/o_rd_tag/o_rd_data), one write port
//        (i_wr_en, i_wr_index, i_wr_tag, i_wr_data).
module icache_line_store
    import icache_pkg::*;
#(
    parameter int unsigned LINES = 32,
    localparam int unsigned IDX_W = index_w(LINES),
    localparam int unsigned TAG_W = tag_w(LINES)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear_valid,
    input  logic [IDX_W-1:0]  i_rd_index,
    output logic              o_rd_valid,
    output logic [TAG_W-1:0]  o_rd_tag,
    output logic [LINE_W-1:0] o_rd_data,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_index,
    input  logic [TAG_W-1:0]  i_wr_tag,
    input  logic [LINE_W-1:0] i_wr_data
);

    logic [LINES-1:0]  r_valid;
    logic [LINES-1:0]  w_valid_next;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [LINE_W-1:0] r_data [LINES];

    // Clear-all first, then the write sets its own line valid again.
    always_comb begin
        w_valid_next = r_valid;
        if (i_clear_valid) begin
            w_valid_next = '0;
        end
        if (i_wr_en) begin
            w_valid_next[i_wr_index] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= '0;
        end else begin
            r_valid <= w_valid_next;
        end
    end

    // Tag and data arrays are not reset; the valid bits guard them.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with whole-line block refill.
// Ports: CLOCK, RESET (sync, active-low); fetch side Address_IN, Read_IN,
//        Flush_IN -> Instruction_OUT, Stall_OUT (combinational hit path);
//        memory side MemBlockRead_OUT, BlockAddress_OUT, InstructionBlock_IN,
//        BlockValid_IN; performance HitCount_OUT, MissCount_OUT.
module instruction_cache
    import icache_pkg::*;
#(
    parameter int unsigned LINES = 32
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [31:0]       Address_IN,
    input  logic              Read_IN,
    input  logic              Flush_IN,
    output logic [31:0]       Instruction_OUT,
    output logic              Stall_OUT,
    output logic              MemBlockRead_OUT,
    output logic [31:0]       BlockAddress_OUT,
    input  logic [255:0]      InstructionBlock_IN,
    input  logic              BlockValid_IN,
    output logic [31:0]       HitCount_OUT,
    output logic [31:0]       MissCount_OUT
);

    localparam int unsigned IDX_W   = index_w(LINES);
    localparam int unsigned TAG_W   = tag_w(LINES);
    localparam int unsigned TAG_LSB = BLOCK_LSB + IDX_W;

    state_e r_state;
    state_e w_state_next;

    logic [31:0]         r_block_addr;
    logic [31:0]         r_hit_count;
    logic [31:0]         r_miss_count;

    logic [IDX_W-1:0]    w_index;
    logic [TAG_W-1:0]    w_tag;
    logic [OFFSET_W-1:0] w_word;
    logic                w_line_valid;
    logic [TAG_W-1:0]    w_line_tag;
    logic [LINE_W-1:0]   w_line_data;
    logic [WORD_W-1:0]   w_word_data;
    logic                w_hit;
    logic                w_miss;
    logic                w_fill;
    logic                w_unused_addr_lsbs;

    assign w_index = Address_IN[TAG_LSB-1:BLOCK_LSB];
    assign w_tag   = Address_IN[ADDR_W-1:TAG_LSB];
    assign w_word  = Address_IN[BLOCK_LSB-1:2];
    assign w_unused_addr_lsbs = ^Address_IN[1:0];

    // A flush in the same cycle forces the lookup to miss.
    assign w_hit  = (r_state == LOOKUP) && Read_IN && !Flush_IN
                    && w_line_valid && (w_line_tag == w_tag);
    assign w_miss = (r_state == LOOKUP) && Read_IN && !w_hit;
    // Fill is gated by reset so a late memory response cannot install a line.
    assign w_fill = RESET && (r_state == REFILL) && BlockValid_IN;

    assign w_word_data = w_line_data[{w_word, 5'b0} +: WORD_W];

    icache_line_store #(
        .LINES (LINES)
    ) u_store (
        .i_clk         (CLOCK),
        .i_rst_n       (RESET),
        .i_clear_valid (Flush_IN),
        .i_rd_index    (w_index),
        .o_rd_valid    (w_line_valid),
        .o_rd_tag      (w_line_tag),
        .o_rd_data     (w_line_data),
        .i_wr_en       (w_fill),
        .i_wr_index    (r_block_addr[TAG_LSB-1:BLOCK_LSB]),
        .i_wr_tag      (r_block_addr[ADDR_W-1:TAG_LSB]),
        .i_wr_data     (InstructionBlock_IN)
    );

    // State register.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            r_state <= LOOKUP;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LOOKUP: if (w_miss)        w_state_next = REFILL;
            REFILL: if (BlockValid_IN) w_state_next = LOOKUP;
        endcase
    end

    // Output logic; everything is held low while reset is asserted.
    always_comb begin
        Stall_OUT        = 1'b0;
        MemBlockRead_OUT = 1'b0;
        Instruction_OUT  = '0;
        if (RESET) begin
            case (r_state)
                LOOKUP: begin
                    if (Read_IN) begin
                        if (w_hit) begin
                            Instruction_OUT = w_word_data;
                        end else begin
                            Stall_OUT = 1'b1;
                        end
                    end
                end
                REFILL: begin
                    Stall_OUT        = 1'b1;
                    MemBlockRead_OUT = 1'b1;
                end
            endcase
        end
    end

    // Performance counters and the latched refill line address.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_block_addr <= '0;
        end else begin
            if (w_hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss) begin
                r_miss_count <= r_miss_count + 32'd1;
                r_block_addr <= {Address_IN[ADDR_W-1:BLOCK_LSB], 5'b0};
            end
        end
    end

    assign BlockAddress_OUT = r_block_addr;
    assign HitCount_OUT     = r_hit_count;
    assign MissCount_OUT    = r_miss_count;

endmodule

// File: tb/tb_instruction_cache.sv
module tb_instruction_cache;

    localparam int unsigned LINES = 32;
    localparam int unsigned IW    = 5;

    logic         CLOCK = 1'b0;
    logic         RESET;
    logic [31:0]  Address_IN;
    logic         Read_IN;
    logic         Flush_IN;
    logic [31:0]  Instruction_OUT;
    logic         Stall_OUT;
    logic         MemBlockRead_OUT;
    logic [31:0]  BlockAddress_OUT;
    logic [255:0] InstructionBlock_IN;
    logic         BlockValid_IN;
    logic [31:0]  HitCount_OUT;
    logic [31:0]  MissCount_OUT;

    always #5 CLOCK = ~CLOCK;

    instruction_cache #(.LINES(LINES)) dut (
        .CLOCK               (CLOCK),
        .RESET               (RESET),
        .Address_IN          (Address_IN),
        .Read_IN             (Read_IN),
        .Flush_IN            (Flush_IN),
        .Instruction_OUT     (Instruction_OUT),
        .Stall_OUT           (Stall_OUT),
        .MemBlockRead_OUT    (MemBlockRead_OUT),
        .BlockAddress_OUT    (BlockAddress_OUT),
        .InstructionBlock_IN (InstructionBlock_IN),
        .BlockValid_IN       (BlockValid_IN),
        .HitCount_OUT        (HitCount_OUT),
        .MissCount_OUT       (MissCount_OUT)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: which line address each slot holds, plus pending refill.
    bit          m_valid [LINES];
    logic [31:0] m_laddr [LINES];
    bit          m_refill = 1'b0;
    logic [31:0] m_blk    = '0;
    logic [31:0] m_hits   = '0;
    logic [31:0] m_misses = '0;

    // Memory contents: word i of line 0x00400000 is 0x10000000+i, and so on.
    function automatic logic [31:0] mem_word(input logic [31:0] la, input int i);
        return 32'h1000_0000 + (la - 32'h0040_0000) + 32'(i);
    endfunction

    function automatic logic [255:0] mem_block(input logic [31:0] la);
        logic [255:0] b;
        for (int i = 0; i < 8; i++) b[32*i +: 32] = mem_word(la, i);
        return b;
    endfunction

    function automatic logic [255:0] junk_block();
        logic [255:0] b;
        for (int i = 0; i < 8; i++) b[32*i +: 32] = $urandom();
        return b;
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'(a[5+IW-1:5]);
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return {a[31:5], 5'b0};
    endfunction

    function automatic bit model_hit();
        int ix;
        ix = idx_of(Address_IN);
        return !Flush_IN && m_valid[ix] && (m_laddr[ix] == line_of(Address_IN));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every observable output against the model for the current cycle.
    task automatic model_check();
        logic [31:0] e_instr;
        logic        e_stall;
        logic        e_mbr;
        e_instr = '0;
        e_stall = 1'b0;
        e_mbr   = 1'b0;
        if (RESET) begin
            if (m_refill) begin
                e_stall = 1'b1;
                e_mbr   = 1'b1;
            end else if (Read_IN) begin
                if (model_hit()) e_instr = mem_word(line_of(Address_IN), int'(Address_IN[4:2]));
                else             e_stall = 1'b1;
            end
        end
        chk("stall", 32'(Stall_OUT), 32'(e_stall));
        chk("memread", 32'(MemBlockRead_OUT), 32'(e_mbr));
        chk("instr", Instruction_OUT, e_instr);
        chk("blockaddr", BlockAddress_OUT, m_blk);
        chk("hits", HitCount_OUT, m_hits);
        chk("misses", MissCount_OUT, m_misses);
    endtask

    // Advance the model across the rising edge using the applied inputs.
    task automatic model_update();
        bit h;
        int ix;
        if (!RESET) begin
            m_refill = 1'b0;
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_hits   = '0;
            m_misses = '0;
            m_blk    = '0;
        end else begin
            h = model_hit();
            if (Flush_IN) foreach (m_valid[i]) m_valid[i] = 1'b0;
            if (m_refill) begin
                if (BlockValid_IN) begin
                    ix = idx_of(m_blk);
                    m_valid[ix] = 1'b1;
                    m_laddr[ix] = m_blk;
                    m_refill    = 1'b0;
                end
            end else if (Read_IN) begin
                if (h) m_hits++;
                else begin
                    m_misses++;
                    m_blk    = line_of(Address_IN);
                    m_refill = 1'b1;
                end
            end
        end
    endtask

    task automatic drive(input bit rst, input bit rd, input bit fl, input bit bv,
                         input logic [31:0] a);
        @(negedge CLOCK);
        RESET         = rst;
        Read_IN       = rd;
        Flush_IN      = fl;
        BlockValid_IN = bv;
        Address_IN    = a;
        InstructionBlock_IN = (bv && m_refill) ? mem_block(m_blk) : junk_block();
        #1;
    endtask

    task automatic tick();
        @(posedge CLOCK);
        model_update();
    endtask

    task automatic cyc(input bit rst, input bit rd, input bit fl, input bit bv,
                       input logic [31:0] a);
        drive(rst, rd, fl, bv, a);
        model_check();
        tick();
    endtask

    // Hold the fetch address through a refill of the given latency.
    task automatic serve(input logic [31:0] a, input int lat);
        for (int k = 0; k < lat; k++) cyc(1, 1, 0, 0, a);
        cyc(1, 1, 0, 1, a);
    endtask

    initial begin
        logic [31:0] addr;
        bit rst, rd, fl, bv;
        foreach (m_valid[i]) begin
            m_valid[i] = 1'b0;
            m_laddr[i] = '0;
        end

        // Initial reset cycles; outputs are unknown until the first edge.
        drive(0, 0, 0, 0, 32'h0);
        tick();
        drive(0, 1, 0, 0, 32'h0040_0000);
        model_check();
        tick();

        // Cold miss with a three-cycle memory latency.
        drive(1, 1, 0, 0, 32'h0040_0000);
        model_check();
        chk("cold_stall0", 32'(Stall_OUT), 32'd1);
        tick();
        drive(1, 1, 0, 0, 32'h0040_0000);
        model_check();
        chk("cold_memread", 32'(MemBlockRead_OUT), 32'd1);
        chk("cold_blockaddr", BlockAddress_OUT, 32'h0040_0000);
        tick();
        cyc(1, 1, 0, 0, 32'h0040_0000);
        cyc(1, 1, 0, 1, 32'h0040_0000);
        drive(1, 1, 0, 0, 32'h0040_0000);
        model_check();
        chk("cold_instr", Instruction_OUT, 32'h1000_0000);
        chk("cold_nostall", 32'(Stall_OUT), 32'd0);
        chk("cold_memread_low", 32'(MemBlockRead_OUT), 32'd0);
        tick();

        // Remaining words of the same line hit back to back.
        for (int k = 1; k < 8; k++) begin
            drive(1, 1, 0, 0, 32'h0040_0000 + 32'(4 * k));
            model_check();
            chk("sameline_instr", Instruction_OUT, 32'h1000_0000 + 32'(k));
            tick();
        end
        drive(1, 0, 0, 0, 32'h0);
        model_check();
        chk("sameline_hits", HitCount_OUT, 32'd8);
        chk("sameline_misses", MissCount_OUT, 32'd1);
        tick();

        // Conflict on index 0 with a different tag.
        cyc(1, 1, 0, 0, 32'h0040_0400);
        serve(32'h0040_0400, 1);
        drive(1, 1, 0, 0, 32'h0040_0404);
        model_check();
        chk("conflict_instr", Instruction_OUT, 32'h1000_0401);
        tick();
        drive(1, 1, 0, 0, 32'h0040_0000);
        model_check();
        chk("conflict_remiss", 32'(Stall_OUT), 32'd1);
        tick();
        serve(32'h0040_0000, 2);

        // Flush invalidates a resident line.
        cyc(1, 1, 0, 0, 32'h0040_0000);
        cyc(1, 0, 1, 0, 32'h0);
        drive(1, 1, 0, 0, 32'h0040_0000);
        model_check();
        chk("flush_miss", 32'(Stall_OUT), 32'd1);
        tick();
        drive(1, 1, 0, 0, 32'h0040_0000);
        model_check();
        chk("flush_blockaddr", BlockAddress_OUT, 32'h0040_0000);
        tick();
        serve(32'h0040_0000, 0);

        // Reset in the middle of a refill drops it; a late response is ignored.
        cyc(1, 1, 0, 0, 32'h0040_0020);
        cyc(1, 1, 0, 0, 32'h0040_0020);
        drive(0, 1, 0, 0, 32'h0040_0020);
        model_check();
        chk("rst_memread", 32'(MemBlockRead_OUT), 32'd0);
        tick();
        drive(1, 0, 0, 1, 32'h0040_0020);
        model_check();
        chk("rst_memread_after", 32'(MemBlockRead_OUT), 32'd0);
        chk("rst_misses", MissCount_OUT, 32'd0);
        chk("rst_hits", HitCount_OUT, 32'd0);
        tick();
        drive(1, 1, 0, 0, 32'h0040_0020);
        model_check();
        chk("rst_next_miss", 32'(Stall_OUT), 32'd1);
        tick();
        serve(32'h0040_0020, 1);

        // Flush coincident with the refill response keeps only the new line.
        cyc(1, 1, 0, 0, 32'h0040_0000);
        serve(32'h0040_0000, 1);
        cyc(1, 1, 0, 0, 32'h0040_0060);
        cyc(1, 1, 0, 0, 32'h0040_0060);
        cyc(1, 1, 1, 1, 32'h0040_0060);
        drive(1, 1, 0, 0, 32'h0040_0064);
        model_check();
        chk("flushfill_hit", 32'(Stall_OUT), 32'd0);
        chk("flushfill_instr", Instruction_OUT, 32'h1000_0061);
        tick();
        drive(1, 1, 0, 0, 32'h0040_0000);
        model_check();
        chk("flushfill_other", 32'(Stall_OUT), 32'd1);
        tick();
        serve(32'h0040_0000, 0);

        // Randomised traffic over 64 lines sharing 32 slots.
        addr = 32'h0040_0000;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) != 0);
            rd  = ($urandom_range(0, 9) < 8);
            fl  = ($urandom_range(0, 49) == 0);
            bv  = m_refill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
            if (!(m_refill && $urandom_range(0, 9) < 7))
                addr = 32'h0040_0000 + (32'($urandom_range(0, 63)) << 5)
                       + 32'($urandom_range(0, 31));
            cyc(rst, rd, fl, bv, addr);
        end
        drive(1, 0, 0, 0, 32'h0);
        model_check();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_cache.md
# instruction_cache

Direct-mapped, read-only instruction cache between the pipeline's fetch address/instruction ports and the block-capable instruction memory. It serves 32-bit fetches from 256-bit (8-word) lines. A miss holds the pipeline and refills one whole line through a request/valid block-read handshake. It also keeps hit and miss counters for performance runs.

## Interface
- `LINES`, default 32, number of lines; power of two, 2..256.
- `CLOCK`  in  1  system clock; all state updates on the rising edge.
- `RESET`  in  1  synchronous, active-low reset.
- `Address_IN`  in  32  fetch byte address; bits [1:0] are ignored.
- `Read_IN`  in  1  fetch request this cycle.
- `Flush_IN`  in  1  invalidate all lines.
- `Instruction_OUT`  out  32  fetched word; valid when `Read_IN=1` and `Stall_OUT=0`.
- `Stall_OUT`  out  1  fetch not satisfied; the pipeline holds its PC and the IF/ID register.
- `MemBlockRead_OUT`  out  1  block-read request to memory.
- `BlockAddress_OUT`  out  32  32-byte-aligned line address; bits [4:0] are 0.
- `InstructionBlock_IN`  in  256  refill data; word *i* is in bits [32i+31:32i].
- `BlockValid_IN`  in  1  refill data valid; single-cycle pulse.
- `HitCount_OUT`  out  32  hit counter.
- `MissCount_OUT`  out  32  miss counter.

## Operation
- Address split: word offset = [4:2]; index = [4+log2(LINES):5]; tag = the remaining upper bits.
- Each line stores a valid bit, a tag and 256 data bits.
- State machine:
  - LOOKUP:
    - Hit when `Read_IN` is set, the indexed line is valid and the tags match.
    - On a hit, `Instruction_OUT` = the selected word, `Stall_OUT=0`, and `HitCount` is incremented.
    - On a miss, `Stall_OUT=1` and `MissCount` is incremented. The line address is latched into `BlockAddress_OUT`, and the next state is REFILL.
    - When `Read_IN=0`, `Stall_OUT=0`, `Instruction_OUT=0`, and no counter changes.
  - REFILL:
    - `MemBlockRead_OUT=1` and `Stall_OUT=1`; `BlockAddress_OUT` holds its value.
    - When `BlockValid_IN=1`, the line is written: data, tag from the latched address, valid=1. The next state is LOOKUP.
  - LOOKUP after a refill re-evaluates the current `Address_IN`. If the address changed, it may miss again, and that miss is counted again.
- `Flush_IN` clears every valid bit in one cycle, in either state.
  - A flush in LOOKUP forces a miss for that cycle's lookup. That lookup is not counted as a hit.
  - A flush during REFILL does not abort the refill. The returning line is installed valid.
  - A flush and a `BlockValid_IN` in the same cycle: all valid bits clear, then the refilled line is set valid.
- `BlockValid_IN` in LOOKUP is ignored.
- Counters wrap modulo 2^32.
- Reset (`RESET=0`):
  - Effects: state goes to LOOKUP, all valid bits clear, counters and `BlockAddress_OUT` go to 0, and any outstanding request is dropped.
  - Output values: `Stall_OUT`, `MemBlockRead_OUT` and `Instruction_OUT` are 0 while reset is asserted.
  - Data and tag arrays are not cleared.

## Timing
- Hit: 0-cycle latency; `Instruction_OUT` and `Stall_OUT` are combinational from `Address_IN` in the same cycle.
- Miss, cycle 0: `Stall_OUT=1`.
- Miss, cycle 1 onward: `MemBlockRead_OUT=1` until and including the cycle in which `BlockValid_IN=1` (cycle N).
- Cycle N+1: lookup hits, `Stall_OUT=0`.
- Total miss penalty = memory latency + 1 cycles.
- `MemBlockRead_OUT` falls in cycle N+1 and never glitches high in LOOKUP.
- Reset mid-REFILL: `MemBlockRead_OUT=0` on the next cycle. A late `BlockValid_IN` is ignored.

## Structure
- Package `icache_pkg` contains:
  - the state enum {LOOKUP, REFILL};
  - line width 256, words per line 8;
  - functions deriving the index and tag widths from `LINES`.
- Sub-module `icache_line_store` holds the valid/tag/data arrays:
  - combinational read port;
  - one write port;
  - a clear-all-valid input.
- The top level holds the FSM, the latched address and the counters.

## Test plan
- Cold miss: reset, then `Read_IN=1`, `Address_IN=0x00400000`.
  - `Stall_OUT=1`, then `MemBlockRead_OUT=1` with `BlockAddress_OUT=0x00400000`.
  - Memory pulses `BlockValid_IN` 3 cycles later with word *i* = 0x10000000+*i*.
  - The next cycle returns `Instruction_OUT=0x10000000`, `Stall_OUT=0`. MissCount=1, HitCount=1.
- Same-line hits: addresses 0x00400004 … 0x0040001C in consecutive cycles → words 0x10000001 … 0x10000007, no stall, HitCount += 7.
- Conflict (`LINES=32`): fetch 0x00400400 (same index 0, different tag) → miss and refill. A following fetch of 0x00400000 misses again.
- Flush: after filling 0x00400000, pulse `Flush_IN`, then fetch 0x00400000 → miss, `BlockAddress_OUT=0x00400000`.
- Reset mid-refill: drop `RESET` while in REFILL, then pulse `BlockValid_IN` after reset → no line installed. Counters=0, `MemBlockRead_OUT=0`, and the next fetch misses.
- Flush and `BlockValid_IN` in the same cycle → the refilled line hits next cycle; all other lines miss.
